// File: rtl/apb_pkg.sv
// Shared types for the APB initiator: state encoding, default widths and
// command/response bundles.
package apb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  // Width of the ACCESS-phase timeout counter; covers limits up to 256.
  localparam int TIMER_W    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
    logic [7:0]            wait_cnt;
  } apb_cmd_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_timer.sv
// Counts ACCESS cycles without pready and flags when the programmed limit is
// reached. A limit of 0 disables expiry. The counter never wraps.
module apb_timeout_timer
  import apb_pkg::*;
#(
  parameter int CNT_W = TIMER_W
) (
  input  logic           pclk,
  input  logic           preset,
  input  logic           clear,
  input  logic           enable,
  input  logic [CNT_W:0] limit,
  output logic           expired
);

  logic [CNT_W-1:0] count;

  // Expiry is seen during the cycle in which the count equals limit-1, so the
  // limit-th stalled ACCESS cycle is the last one.
  assign expired = (limit != '0) &&
                   ({1'b0, count} == (limit - (CNT_W+1)'(1)));

  // Stall counter: cleared when a command is accepted, saturates at expiry.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: takes one read/write command at a time, runs
// IDLE -> SETUP -> ACCESS on the bus and returns a one-cycle response strobe.
//
// Command handshake: a command transfers on a rising edge where
// cmd_valid && cmd_ready; cmd_ready is high only in IDLE (and never during
// reset), and command inputs are don't-care whenever cmd_ready is low.
// rsp_valid has no back-pressure: it is a single-cycle strobe.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [7:0]        cmd_wait,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic [7:0]        pwait,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata,
  output apb_state_t        dbg_state
);

  apb_state_t state;
  logic       accept;
  logic       tmo_expired;

  assign cmd_ready = preset && (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  apb_timeout_timer #(.CNT_W(TIMER_W)) u_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (accept),
    .enable  ((state == ACCESS) && !pready),
    .limit   ((TIMER_W+1)'(TIMEOUT)),
    .expired (tmo_expired)
  );

  // Bus protocol FSM; every bus and response output is a register here.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pwait     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= cmd_write;
            paddr   <= cmd_addr;
            pwdata  <= cmd_wdata;
            pwait   <= cmd_wait;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          // pready is checked first so a same-edge timeout still succeeds.
          if (pready) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (tmo_expired) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
